// File: rtl/blink_pkg.sv
// blink_pkg: shared constants, mode codes and FSM states for the LED blink pattern scheduler
package blink_pkg;
  localparam int N_LED = 18;
  localparam logic [2:0] MODE_CHASE = 3'd0;
  localparam logic [2:0] MODE_FILL = 3'd1;
  localparam logic [2:0] MODE_ALT = 3'd2;
  localparam logic [2:0] MODE_BLINK = 3'd3;
  localparam logic [2:0] MODE_SPARKLE = 3'd4;
  localparam logic [2:0] MODE_LAST = 3'd4;
  localparam logic [N_LED-1:0] LFSR_SEED = 18'h00001;
  localparam int LFSR_TAP_A = 17;
  localparam int LFSR_TAP_B = 10;
  typedef enum logic [1:0] {IDLE, RUN, GAP} fsm_t;
  function automatic logic [2:0] next_mode(logic [2:0] m);
    return m >= MODE_LAST ? MODE_CHASE : m + 3'd1;
  endfunction
endpackage

// File: rtl/blink_if.sv
// blink_if: control inputs and display outputs of the blink pattern scheduler
interface blink_if;
  import blink_pkg::*;
  logic en;
  logic hold;
  logic next_req;
  logic [N_LED-1:0] led;
  logic [2:0] mode;
  logic step_tick;
  modport master(output en, hold, next_req, input led, mode, step_tick);
  modport slave(input en, hold, next_req, output led, mode, step_tick);
endinterface

// File: rtl/blink_prescaler.sv
// blink_prescaler: divides clk by TICK_DIV into a registered one-cycle step tick
module blink_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst || clr) begin
      cnt <= '0;
      tick <= 1'b0;
    end else if (run) begin
      cnt <= cnt == W'(TICK_DIV - 1) ? '0 : cnt + 1'b1;
      tick <= cnt == W'(TICK_DIV - 1);
    end else
      tick <= 1'b0;
endmodule

// File: rtl/blink_pattern_scheduler.sv
// blink_pattern_scheduler: steps the LED tree through the blink playlist with dark gaps between modes
module blink_pattern_scheduler
  import blink_pkg::*;
#(
  parameter int TICK_DIV = 4,
  parameter int MODE_STEPS = 36,
  parameter int GAP_STEPS = 2
) (
  input logic clk,
  input logic rst,
  blink_if.slave bus
);
  localparam int SW = $clog2(MODE_STEPS + 1);
  localparam int GW = $clog2(GAP_STEPS + 1);
  fsm_t fsm;
  logic [2:0] mode;
  logic [4:0] p;
  logic [SW-1:0] step_cnt;
  logic [GW-1:0] gap_cnt;
  logic [N_LED-1:0] lfsr;
  logic tick;
  logic skip;
  assign skip = fsm == RUN && bus.next_req;
  // a skip restarts the tick phase so the gap always lasts full steps
  blink_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
    .clk(clk),
    .rst(rst),
    .clr(!bus.en || skip),
    .run(fsm != IDLE),
    .tick(tick)
  );
  function automatic logic [N_LED-1:0] render(fsm_t s, logic [2:0] m, logic [4:0] q, logic [N_LED-1:0] r);
    logic [N_LED-1:0] one;
    one = N_LED'(1);
    return s != RUN ? '0 :
      m == MODE_CHASE ? one << q :
      m == MODE_FILL ? (one << (q + 5'd1)) - one :
      m == MODE_ALT ? (q[0] ? {(N_LED/2){2'b10}} : {(N_LED/2){2'b01}}) :
      m == MODE_BLINK ? {N_LED{~q[0]}} : r;
  endfunction
  assign bus.led = render(fsm, mode, p, lfsr);
  assign bus.mode = mode;
  assign bus.step_tick = tick;
  always_ff @(posedge clk)
    if (rst) begin
      fsm <= IDLE;
      mode <= MODE_CHASE;
      p <= '0;
      step_cnt <= '0;
      gap_cnt <= '0;
      lfsr <= LFSR_SEED;
    end else if (!bus.en) begin
      fsm <= IDLE;
      p <= '0;
      step_cnt <= '0;
      gap_cnt <= '0;
    end else
      case (fsm)
        IDLE: fsm <= RUN;
        RUN:
          if (bus.next_req) begin
            fsm <= GAP;
            gap_cnt <= '0;
          end else if (tick) begin
            p <= p == 5'(N_LED - 1) ? '0 : p + 5'd1;
            step_cnt <= bus.hold ? '0 : step_cnt + 1'b1;
            if (mode == MODE_SPARKLE) lfsr <= {lfsr[N_LED-2:0], lfsr[LFSR_TAP_A] ^ lfsr[LFSR_TAP_B]};
            if (!bus.hold && step_cnt == SW'(MODE_STEPS - 1)) begin
              fsm <= GAP;
              gap_cnt <= '0;
            end
          end
        GAP:
          if (tick) begin
            if (gap_cnt == GW'(GAP_STEPS - 1)) begin
              fsm <= RUN;
              mode <= next_mode(mode);
              p <= '0;
              step_cnt <= '0;
            end else
              gap_cnt <= gap_cnt + 1'b1;
          end
        default: fsm <= IDLE;
      endcase
endmodule

// File: tb/tb_blink_pattern_scheduler.sv
// tb_blink_pattern_scheduler: directed scenarios plus random traffic against a rule-level model
module tb_blink_pattern_scheduler;
  localparam int TD = 2;
  localparam int MS = 4;
  localparam int GS = 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_run = 0;
  int n_fail = 0;
  int m_st = 0;
  int m_mode = 0;
  int m_pos = 0;
  int m_steps = 0;
  int m_gaps = 0;
  int m_pre = 0;
  bit m_tick = 1'b0;
  logic [17:0] m_lfsr = 18'h1;
  always #25 clk = ~clk;
  blink_if bus();
  blink_pattern_scheduler #(.TICK_DIV(TD), .MODE_STEPS(MS), .GAP_STEPS(GS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  function automatic logic [17:0] exp_led();
    if (m_st != 1) return 18'h0;
    case (m_mode)
      0: return 18'(1 << m_pos);
      1: return 18'((1 << (m_pos + 1)) - 1);
      2: return (m_pos % 2) != 0 ? 18'h2AAAA : 18'h15555;
      3: return (m_pos % 2) != 0 ? 18'h0 : 18'h3FFFF;
      default: return m_lfsr;
    endcase
  endfunction
  // model state: 0 idle, 1 running a mode, 2 dark gap
  task automatic model_step();
    bit nt;
    nt = 1'b0;
    if (rst) begin
      m_st = 0; m_mode = 0; m_pos = 0; m_steps = 0; m_gaps = 0; m_pre = 0; m_tick = 0; m_lfsr = 18'h1;
    end else if (!bus.en) begin
      m_st = 0; m_pos = 0; m_steps = 0; m_gaps = 0; m_pre = 0; m_tick = 0;
    end else begin
      if (m_st == 1 && bus.next_req) m_pre = 0;
      else if (m_st != 0) begin
        nt = (m_pre == TD - 1);
        m_pre = (m_pre + 1) % TD;
      end
      if (m_st == 0) m_st = 1;
      else if (m_st == 1) begin
        if (bus.next_req) begin
          m_st = 2; m_gaps = 0;
        end else if (m_tick) begin
          m_pos = (m_pos + 1) % 18;
          if (m_mode == 4) m_lfsr = {m_lfsr[16:0], m_lfsr[17] ^ m_lfsr[10]};
          if (!bus.hold && m_steps == MS - 1) begin
            m_st = 2; m_gaps = 0;
          end
          m_steps = bus.hold ? 0 : m_steps + 1;
        end
      end else if (m_tick) begin
        if (m_gaps == GS - 1) begin
          m_st = 1; m_mode = (m_mode + 1) % 5; m_pos = 0; m_steps = 0;
        end else m_gaps++;
      end
      m_tick = nt;
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask
  task automatic test_reset();
    rst = 1'b1; bus.en = 1'b1; bus.hold = 1'b0; bus.next_req = 1'b0;
    cyc();
    n_run++; if (bus.led !== 18'h0) begin n_fail++; $display("FAIL reset_led: got %h want 00000", bus.led); end
    n_run++; if (bus.mode !== 3'd0) begin n_fail++; $display("FAIL reset_mode: got %0d want 0", bus.mode); end
    n_run++; if (bus.step_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", bus.step_tick); end
    rst = 1'b0;
  endtask
  task automatic test_playlist(input bit do_rst);
    logic [17:0] prev;
    logic [17:0] seq[$];
    logic [17:0] want[9];
    want = '{18'h1, 18'h2, 18'h4, 18'h8, 18'h0, 18'h1, 18'h3, 18'h7, 18'hF};
    if (do_rst) begin rst = 1'b1; cyc(); rst = 1'b0; end
    bus.en = 1'b1; bus.hold = 1'b0; bus.next_req = 1'b0;
    prev = bus.led;
    for (int i = 0; i < 30; i++) begin
      cyc();
      n_run++;
      if (bus.led !== exp_led() || bus.mode !== 3'(m_mode)) begin
        n_fail++; $display("FAIL playlist_cycle%0d: got led %h mode %0d want led %h mode %0d", i, bus.led, bus.mode, exp_led(), m_mode);
      end
      if (bus.led !== prev) begin seq.push_back(bus.led); prev = bus.led; end
    end
    for (int i = 0; i < 9; i++) begin
      n_run++;
      if (i >= seq.size() || seq[i] !== want[i]) begin
        n_fail++; $display("FAIL playlist_seq%0d: got %h want %h", i, i < seq.size() ? seq[i] : 18'h0, want[i]);
      end
    end
  endtask
  task automatic test_next_req();
    rst = 1'b1; bus.en = 1'b1; bus.hold = 1'b0; bus.next_req = 1'b0; cyc(); rst = 1'b0;
    for (int i = 0; i < 20 && bus.led !== 18'h2; i++) cyc();
    n_run++; if (bus.led !== 18'h2) begin n_fail++; $display("FAIL skip_reach: got %h want 00002", bus.led); end
    bus.next_req = 1'b1; cyc();
    n_run++; if (bus.led !== 18'h0 || bus.mode !== 3'd0) begin n_fail++; $display("FAIL skip_gap: got led %h mode %0d want 00000 mode 0", bus.led, bus.mode); end
    cyc(); bus.next_req = 1'b0;
    for (int i = 0; i < 20 && bus.mode !== 3'd1; i++) cyc();
    n_run++; if (bus.mode !== 3'd1 || bus.led !== 18'h1) begin n_fail++; $display("FAIL skip_mode1: got led %h mode %0d want 00001 mode 1", bus.led, bus.mode); end
    cyc(); cyc();
    n_run++; if (bus.mode !== 3'd1) begin n_fail++; $display("FAIL skip_in_gap_ignored: got mode %0d want 1", bus.mode); end
  endtask
  task automatic test_hold();
    logic [17:0] prev;
    bit wrapped;
    wrapped = 1'b0;
    rst = 1'b1; bus.en = 1'b1; bus.hold = 1'b1; bus.next_req = 1'b0; cyc(); rst = 1'b0;
    prev = bus.led;
    for (int i = 0; i < 44; i++) begin
      cyc();
      n_run++; if (bus.mode !== 3'd0) begin n_fail++; $display("FAIL hold_mode%0d: got %0d want 0", i, bus.mode); end
      n_run++; if (bus.led !== exp_led()) begin n_fail++; $display("FAIL hold_led%0d: got %h want %h", i, bus.led, exp_led()); end
      if (prev === 18'h20000 && bus.led === 18'h1) wrapped = 1'b1;
      prev = bus.led;
    end
    n_run++; if (!wrapped) begin n_fail++; $display("FAIL hold_wrap: got no 20000->00001 want wrap"); end
    bus.hold = 1'b0;
  endtask
  task automatic test_sparkle();
    logic [17:0] prev;
    rst = 1'b1; bus.en = 1'b1; bus.hold = 1'b0; bus.next_req = 1'b0; cyc(); rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      for (int i = 0; i < 40 && m_st != 1; i++) cyc();
      bus.next_req = 1'b1; cyc(); bus.next_req = 1'b0;
      for (int i = 0; i < 40 && bus.mode !== 3'(k); i++) cyc();
      n_run++; if (bus.mode !== 3'(k)) begin n_fail++; $display("FAIL sparkle_mode%0d: got %0d want %0d", k, bus.mode, k); end
      if (k == 3) begin
        n_run++; if (bus.led !== 18'h3FFFF) begin n_fail++; $display("FAIL blink_on: got %h want 3ffff", bus.led); end
        prev = bus.led;
        for (int i = 0; i < 10 && bus.led === prev; i++) cyc();
        n_run++; if (bus.led !== 18'h0) begin n_fail++; $display("FAIL blink_off: got %h want 00000", bus.led); end
      end
      if (k == 4) begin
        n_run++; if (bus.led !== 18'h1) begin n_fail++; $display("FAIL sparkle_seed: got %h want 00001", bus.led); end
        prev = bus.led;
        for (int i = 0; i < 10 && bus.led === prev; i++) cyc();
        n_run++; if (bus.led !== 18'h2) begin n_fail++; $display("FAIL sparkle_step1: got %h want 00002", bus.led); end
        prev = bus.led;
        for (int i = 0; i < 10 && bus.led === prev; i++) cyc();
        n_run++; if (bus.led !== 18'h4) begin n_fail++; $display("FAIL sparkle_step2: got %h want 00004", bus.led); end
      end
    end
  endtask
  task automatic test_en_drop();
    rst = 1'b1; bus.en = 1'b1; bus.hold = 1'b0; bus.next_req = 1'b0; cyc(); rst = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      for (int i = 0; i < 40 && m_st != 1; i++) cyc();
      bus.next_req = 1'b1; cyc(); bus.next_req = 1'b0;
      for (int i = 0; i < 40 && bus.mode !== 3'(k); i++) cyc();
    end
    cyc(); cyc(); cyc();
    bus.en = 1'b0; cyc();
    n_run++; if (bus.led !== 18'h0 || bus.mode !== 3'd2) begin n_fail++; $display("FAIL en_off: got led %h mode %0d want 00000 mode 2", bus.led, bus.mode); end
    for (int i = 0; i < 4; i++) begin
      n_run++; if (bus.step_tick !== 1'b0) begin n_fail++; $display("FAIL en_off_tick%0d: got %b want 0", i, bus.step_tick); end
      cyc();
    end
    bus.en = 1'b1; cyc();
    n_run++; if (bus.mode !== 3'd2 || bus.led !== 18'h15555) begin n_fail++; $display("FAIL en_resume: got led %h mode %0d want 15555 mode 2", bus.led, bus.mode); end
  endtask
  task automatic test_rst_gap();
    rst = 1'b1; bus.en = 1'b1; bus.hold = 1'b0; bus.next_req = 1'b0; cyc(); rst = 1'b0;
    bus.next_req = 1'b1; cyc(); bus.next_req = 1'b0;
    for (int i = 0; i < 20 && bus.mode !== 3'd1; i++) cyc();
    bus.next_req = 1'b1; cyc(); bus.next_req = 1'b0;
    n_run++; if (bus.led !== 18'h0 || bus.mode !== 3'd1) begin n_fail++; $display("FAIL rstgap_gap: got led %h mode %0d want 00000 mode 1", bus.led, bus.mode); end
    rst = 1'b1; bus.next_req = 1'b1; cyc(); bus.next_req = 1'b0;
    n_run++; if (bus.led !== 18'h0 || bus.mode !== 3'd0 || bus.step_tick !== 1'b0) begin
      n_fail++; $display("FAIL rstgap_reset: got led %h mode %0d tick %b want 00000 mode 0 tick 0", bus.led, bus.mode, bus.step_tick);
    end
    rst = 1'b0;
    test_playlist(1'b0);
  endtask
  task automatic test_random();
    rst = 1'b1; bus.en = 1'b1; bus.hold = 1'b0; bus.next_req = 1'b0; cyc(); rst = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      rst = $urandom_range(0, 199) == 0;
      bus.en = $urandom_range(0, 24) != 0;
      if ($urandom_range(0, 15) == 0) bus.hold = ~bus.hold;
      bus.next_req = $urandom_range(0, 11) == 0;
      cyc();
      n_run++;
      if (bus.led !== exp_led() || bus.mode !== 3'(m_mode) || bus.step_tick !== m_tick) begin
        n_fail++;
        $display("FAIL random%0d: got led %h mode %0d tick %b want led %h mode %0d tick %b", i, bus.led, bus.mode, bus.step_tick, exp_led(), m_mode, m_tick);
      end
    end
    rst = 1'b0; bus.next_req = 1'b0; bus.hold = 1'b0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.en = 1'b0; bus.hold = 1'b0; bus.next_req = 1'b0;
    @(negedge clk);
    test_reset();
    test_playlist(1'b1);
    test_next_req();
    test_hold();
    test_sparkle();
    test_en_drop();
    test_rst_gap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
